// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. Free-running horizontal and vertical
// counters advance on pixel ticks. Their decode is registered into sync, DE,
// pixel coordinates and single-clock event pulses. An optional shift register
// delays sync/DE so they stay aligned with a downstream pixel pipeline.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   pix_en       in   pixel tick; timing advances only on clk edges with pix_en=1
//   h_sync       out  horizontal sync, at HS_POL level while asserted (delayed)
//   v_sync       out  vertical sync, at VS_POL level while asserted (delayed)
//   disp_en      out  high inside the active area (delayed)
//   x            out  pixel column, 0-based, undelayed
//   y            out  pixel row, 0-based, undelayed
//   line_start   out  one-clk pulse at x=0 of every line
//   frame_start  out  one-clk pulse at x=0, y=0
//   vblank_start out  one-clk pulse at x=0, y=V_ACTIVE
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 0,
    parameter int HW       = 11,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          disp_en,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYN_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYN_END = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYN_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYN_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic h_act, h_syn, v_act, v_syn;
    logic raw_hs, raw_vs, raw_de;

    // -----------------------------------------------------------------------
    // Position counters. The line wrap and frame wrap share the tick on the
    // last pixel of the frame.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Region decode of the current (pre-increment) counters.
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is assigned on every pass, so no
    // latch can be inferred.
    always_comb begin
        h_act = (h_cnt < H_ACT_END);
        h_syn = (h_cnt >= H_SYN_BEG) && (h_cnt < H_SYN_END);
        v_act = (v_cnt < V_ACT_END);
        v_syn = (v_cnt >= V_SYN_BEG) && (v_cnt < V_SYN_END);
    end

    // -----------------------------------------------------------------------
    // Output registers: lag the counters by exactly one tick.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            raw_de <= 1'b0;
            raw_hs <= ~HS_POL;
            raw_vs <= ~VS_POL;
        end else if (pix_en) begin
            x      <= h_cnt;
            y      <= v_cnt;
            raw_de <= h_act & v_act;
            raw_hs <= h_syn ? HS_POL : ~HS_POL;
            raw_vs <= v_syn ? VS_POL : ~VS_POL;
        end
    end

    // -----------------------------------------------------------------------
    // Event pulses. Cleared on every clk without a tick so each pulse is one
    // clk wide whatever the pix_en duty cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !pix_en) begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= (h_cnt == '0);
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
            vblank_start <= (h_cnt == '0) && (v_cnt == V_ACT_END);
        end
    end

    // -----------------------------------------------------------------------
    // Optional sync/DE delay line; shifts on ticks only. x, y and the pulses
    // are deliberately left undelayed.
    // -----------------------------------------------------------------------
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign h_sync  = raw_hs;
            assign v_sync  = raw_vs;
            assign disp_en = raw_de;
        end else begin : g_dly
            logic [2:0] stage [PIPE_DLY];

            // NOTE: the delay stages are reset explicitly so that sync/DE
            // show the idle levels until real data has shifted through.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        stage[i] <= {~HS_POL, ~VS_POL, 1'b0};
                    end
                end else if (pix_en) begin
                    stage[0] <= {raw_hs, raw_vs, raw_de};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign {h_sync, v_sync, disp_en} = stage[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share clk and rst:
//   u_a : small raster (H 8/2/3/3, V 4/1/2/1), active-low syncs, no delay
//   u_b : same raster, HS_POL=1, PIPE_DLY=3
//   u_d : default 640x480 raster, pix_en every 4th clk
// Expected values come from the raster geometry worked out below, indexed by
// the number of ticks since reset release.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic pix_en_s;
    logic pix_en_d;

    always #5 clk = ~clk;

    logic        a_hs, a_vs, a_de, a_ls, a_fs, a_vb;
    logic [10:0] a_x;
    logic [9:0]  a_y;
    logic        b_hs, b_vs, b_de, b_ls, b_fs, b_vb;
    logic [10:0] b_x;
    logic [9:0]  b_y;
    logic        d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
    logic [10:0] d_x;
    logic [9:0]  d_y;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0)
    ) u_a (
        .clk(clk), .rst(rst), .pix_en(pix_en_s),
        .h_sync(a_hs), .v_sync(a_vs), .disp_en(a_de),
        .x(a_x), .y(a_y),
        .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(3)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pix_en_s),
        .h_sync(b_hs), .v_sync(b_vs), .disp_en(b_de),
        .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vb)
    );

    vga_timing_gen u_d (
        .clk(clk), .rst(rst), .pix_en(pix_en_d),
        .h_sync(d_hs), .v_sync(d_vs), .disp_en(d_de),
        .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Small raster: 16 clocks per line, 8 lines, 128 ticks per frame.
    // h_sync asserted for x=10..12, v_sync asserted for y=5..6.
    function automatic bit s_hsyn(input int xx);
        return (xx >= 10) && (xx <= 12);
    endfunction

    function automatic bit s_vsyn(input int yy);
        return (yy >= 5) && (yy <= 6);
    endfunction

    // u_a after tick number t (0-based since release), at frame position p.
    task automatic check_a(input int p);
        int ex, ey;
        ex = p % 16;
        ey = p / 16;
        check("a.x",  32'(a_x), ex);
        check("a.y",  32'(a_y), ey);
        check("a.de", 32'(a_de), (ex < 8 && ey < 4) ? 1 : 0);
        check("a.hs", 32'(a_hs), s_hsyn(ex) ? 0 : 1);
        check("a.vs", 32'(a_vs), s_vsyn(ey) ? 0 : 1);
        check("a.ls", 32'(a_ls), (ex == 0) ? 1 : 0);
        check("a.fs", 32'(a_fs), (p == 0) ? 1 : 0);
        check("a.vb", 32'(a_vb), (ex == 0 && ey == 4) ? 1 : 0);
    endtask

    // u_b after tick t: x/y/pulses undelayed, sync/DE show position t-3.
    task automatic check_b(input int t);
        int p, ex, ey, p3, dx, dy;
        p  = t % 128;
        ex = p % 16;
        ey = p / 16;
        check("b.x",  32'(b_x), ex);
        check("b.y",  32'(b_y), ey);
        check("b.ls", 32'(b_ls), (ex == 0) ? 1 : 0);
        check("b.fs", 32'(b_fs), (p == 0) ? 1 : 0);
        check("b.vb", 32'(b_vb), (ex == 0 && ey == 4) ? 1 : 0);
        if (t < 3) begin
            check("b.hs_idle", 32'(b_hs), 0);
            check("b.vs_idle", 32'(b_vs), 1);
            check("b.de_idle", 32'(b_de), 0);
        end else begin
            p3 = (t - 3) % 128;
            dx = p3 % 16;
            dy = p3 / 16;
            check("b.hs", 32'(b_hs), s_hsyn(dx) ? 1 : 0);
            check("b.vs", 32'(b_vs), s_vsyn(dy) ? 0 : 1);
            check("b.de", 32'(b_de), (dx < 8 && dy < 4) ? 1 : 0);
        end
    endtask

    // u_d after clk c, with ticks on every clk whose index is a multiple of 4.
    // The last tick was number c/4; pulses only on the tick clk itself.
    task automatic check_d(input int c);
        int dt, ex, ey;
        bit tk;
        dt = c / 4;
        ex = dt % 800;
        ey = dt / 800;
        tk = (c % 4 == 0);
        check("d.x",  32'(d_x), ex);
        check("d.y",  32'(d_y), ey);
        check("d.hs", 32'(d_hs), (ex >= 656 && ex <= 751) ? 0 : 1);
        check("d.vs", 32'(d_vs), (ey >= 490 && ey <= 491) ? 0 : 1);
        check("d.de", 32'(d_de), (ex < 640 && ey < 480) ? 1 : 0);
        check("d.ls", 32'(d_ls), (tk && ex == 0) ? 1 : 0);
        check("d.fs", 32'(d_fs), (tk && ex == 0 && ey == 0) ? 1 : 0);
        check("d.vb", 32'(d_vb), (tk && ex == 0 && ey == 480) ? 1 : 0);
    endtask

    task automatic check_reset();
        check("rst.a.x",  32'(a_x), 0);
        check("rst.a.y",  32'(a_y), 0);
        check("rst.a.de", 32'(a_de), 0);
        check("rst.a.hs", 32'(a_hs), 1);
        check("rst.a.vs", 32'(a_vs), 1);
        check("rst.a.ls", 32'(a_ls), 0);
        check("rst.a.fs", 32'(a_fs), 0);
        check("rst.a.vb", 32'(a_vb), 0);
        check("rst.b.hs", 32'(b_hs), 0);
        check("rst.b.vs", 32'(b_vs), 1);
        check("rst.b.de", 32'(b_de), 0);
        check("rst.b.x",  32'(b_x), 0);
        check("rst.d.x",  32'(d_x), 0);
        check("rst.d.hs", 32'(d_hs), 1);
        check("rst.d.vs", 32'(d_vs), 1);
        check("rst.d.de", 32'(d_de), 0);
    endtask

    // 3494 clocks: covers 27+ small frames (line and frame wraps), one full
    // default line with its sync window at x=656..751, and ends with the
    // small raster at x=5, y=2 (tick 3493 -> position 37).
    localparam int NCLK = 3494;

    initial begin
        // Reset with pix_en high: reset must win.
        rst      = 1'b1;
        pix_en_s = 1'b1;
        pix_en_d = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset();

        rst = 1'b0;
        for (int c = 0; c < NCLK; c++) begin
            pix_en_d = (c % 4 == 0);
            @(posedge clk);
            #1;
            check_a(c % 128);
            check_b(c);
            check_d(c);
        end

        // Position before the mid-frame reset.
        check("pre_rst.a.x", 32'(a_x), 5);
        check("pre_rst.a.y", 32'(a_y), 2);

        // One-clk reset mid-frame, then ten clocks with no tick.
        rst      = 1'b1;
        pix_en_d = 1'b1;
        @(posedge clk);
        #1;
        check_reset();
        rst      = 1'b0;
        pix_en_s = 1'b0;
        pix_en_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_reset();
        end

        // Resume with a tick on every clk for all instances; u_d tick k maps
        // onto check_d(4*k) since its model counts one tick per four clocks.
        pix_en_s = 1'b1;
        pix_en_d = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check_a(k);
            check_b(k);
            check_d(4 * k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
